// File: rtl/hazard_tracker.sv
`timescale 1ns/1ps
// hazard_tracker: shadows the EX/MEM/WB pipeline latches with the {rfWEN, dest, load}
// of each in-flight instruction and exposes a per-register pending mask.
// Latency: a decoded write appears on ex_* one advancing edge after issue, mem_* after two, wb_* after three.
// Backpressure: advance=0 freezes all three entries and takes priority over dx_flush.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   advance                  pipeline moves one stage this cycle (0 = freeze)
//   dx_flush                 replace the decode->EX transfer with a bubble
//   dec_valid/rfWEN/load/dest decoded instruction entering EX
//   ex_*/mem_*/wb_*          registered stage entries
//   pending                  bit r set iff any stage has rfWEN=1 and dest=r
//   bubble_cnt, freeze_cnt   saturating statistics counters
//
// Optional build macro HAZARD_STATS_EN: when defined, bubble_cnt counts flush
// bubbles and freeze_cnt counts frozen cycles. When undefined, both outputs are
// tied to zero and no counter state exists.
module hazard_tracker #(
  parameter int NREGS = 32,
  parameter int CNT_W = 16,
  localparam int DW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             advance,
  input  logic             dx_flush,
  input  logic             dec_valid,
  input  logic             dec_rfWEN,
  input  logic             dec_load,
  input  logic [DW-1:0]    dec_dest,
  output logic             ex_rfWEN,
  output logic [DW-1:0]    ex_dest,
  output logic             ex_load,
  output logic             mem_rfWEN,
  output logic [DW-1:0]    mem_dest,
  output logic             wb_rfWEN,
  output logic [DW-1:0]    wb_dest,
  output logic [NREGS-1:0] pending,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef struct packed {
    logic          wen;
    logic [DW-1:0] dest;
    logic          load;
  } stage_t;

  stage_t ex_q, ex_d;
  stage_t mem_q, mem_d;
  stage_t wb_q, wb_d;

  // Next-state for the three stage entries. Freeze wins over flush; a flushed
  // or invalid decode slot enters EX as an all-zero bubble.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (advance) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (dx_flush || !dec_valid) begin
        ex_d = '0;
      end else begin
        // r0 is hardwired to zero, so writes to it never create a hazard;
        // dest is still captured for visibility.
        ex_d.wen  = dec_rfWEN && (dec_dest != '0);
        ex_d.dest = dec_dest;
        ex_d.load = dec_load;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // OR of one-hot decodes: a register shared by two stages stays pending
  // until the last of them retires.
  always_comb begin
    pending = '0;
    if (ex_q.wen)  pending[ex_q.dest]  = 1'b1;
    if (mem_q.wen) pending[mem_q.dest] = 1'b1;
    if (wb_q.wen)  pending[wb_q.dest]  = 1'b1;
  end

  assign ex_rfWEN  = ex_q.wen;
  assign ex_dest   = ex_q.dest;
  assign ex_load   = ex_q.load;
  assign mem_rfWEN = mem_q.wen;
  assign mem_dest  = mem_q.dest;
  assign wb_rfWEN  = wb_q.wen;
  assign wb_dest   = wb_q.dest;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  // Saturating counters: hold at all-ones rather than wrap.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (advance && dx_flush && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (!advance && (freeze_cnt_q != '1)) begin
      freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt_q <= '0;
      freeze_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`else
  assign bubble_cnt = '0;
  assign freeze_cnt = '0;
`endif

endmodule
